// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the external-SRAM memory-stage controller:
// FSM state encoding and default parameter values.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 5;
  localparam int unsigned DEF_SRAM_ADDR_W = 18;

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter
// Phase timer for one 16-bit SRAM transaction. Counts 0..WAIT_CYCLES-1
// while enabled; 'clear' has priority and returns it to 0.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - advance the count this cycle
//   clear     - force count to 0 on the next edge
//   count     - current count
//   last      - count is at WAIT_CYCLES-1 (final cycle of the phase)
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned CNT_W       = $clog2(WAIT_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl
// Memory-stage controller: turns each 32-bit pipeline load/store into two
// 16-bit transactions (LO half, then HI half) on an asynchronous SRAM and
// holds 'ready' low while the pipeline must freeze.
// Optional feature macro: SRAM_WRITE_POST_EN (posted stores; the pipeline
// is not stalled by a store, which drains in the background).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN  - load / store request (load wins if both)
//   ALU_Res             - byte address
//   Val_RM              - store data
//   memory_out          - load data, held until the next load completes
//   ready               - low freezes the pipeline (combinational)
//   SRAM_ADDR           - half-word address
//   SRAM_DQ_OUT         - write data
//   SRAM_DQ_OE          - data-bus drive enable
//   SRAM_DQ_IN          - read data
//   SRAM_WE_N           - active-low write strobe
//
// state | meaning
// IDLE  | waiting for a request; latches address/data/direction on req
// LO    | transaction on half-word {word,0}, data bits [15:0]
// HI    | transaction on half-word {word,1}, data bits [31:16]
// DONE  | access complete, ready high for one cycle
module sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ALU_Res,
  input  logic [31:0]            Val_RM,
  output logic [31:0]            memory_out,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]            SRAM_DQ_OUT,
  output logic                   SRAM_DQ_OE,
  input  logic [15:0]            SRAM_DQ_IN,
  output logic                   SRAM_WE_N
);

  localparam int unsigned CNT_W  = $clog2(WAIT_CYCLES);
  localparam int unsigned WORD_W = SRAM_ADDR_W - 1;

  sram_state_t       state_q, state_d;
  logic              req, is_wr, start;
  logic              in_phase, near_last, post_drain;
  logic [31:0]       off;
  logic [WORD_W-1:0] req_word, word_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic [15:0]       rd_lo_q;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic              unused_off;

  assign req   = MEM_R_EN | MEM_W_EN;
  assign is_wr = MEM_W_EN & ~MEM_R_EN;

  assign off      = ALU_Res - 32'(BASE_ADDR);
  assign req_word = off[SRAM_ADDR_W:2];
  // Byte-lane bits and address bits beyond the SRAM range are dropped on
  // purpose: no alignment fault, addresses wrap within the SRAM.
  assign unused_off = ^{off[31:SRAM_ADDR_W+1], off[1:0]};

  assign in_phase = (state_q == LO) || (state_q == HI);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .en    (in_phase),
    .clear (~in_phase | cnt_last),
    .count (cnt),
    .last  (cnt_last)
  );

  // Next cycle is the last of the current phase: WE_N must rise there so
  // the data is held past the end of the write strobe.
  assign near_last = in_phase & ~cnt_last & (cnt == CNT_W'(WAIT_CYCLES - 2));

`ifdef SRAM_WRITE_POST_EN
  // A posted store returns straight to IDLE after HI; nobody waits on it.
  assign post_drain = wr_q;
`else
  assign post_drain = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef SRAM_WRITE_POST_EN
        ready = ~req | is_wr;
`else
        ready = ~req;
`endif
        if (req) begin
          state_d = LO;
          start   = 1'b1;
        end
      end
      LO: begin
`ifdef SRAM_WRITE_POST_EN
        // While a posted store drains, only a new request has to wait.
        ready = wr_q & ~req;
`endif
        if (cnt_last) state_d = HI;
      end
      HI: begin
`ifdef SRAM_WRITE_POST_EN
        ready = wr_q & ~req;
`endif
        if (cnt_last) state_d = post_drain ? IDLE : DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches and registered SRAM bus. Bus values are loaded on the
  // edge that enters a phase so they are stable for the whole phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_lo_q     <= '0;
      memory_out  <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_OUT <= '0;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
    end else begin
      if (start) begin
        word_q      <= req_word;
        wdata_q     <= Val_RM;
        wr_q        <= is_wr;
        SRAM_ADDR   <= {req_word, 1'b0};
        SRAM_DQ_OUT <= Val_RM[15:0];
        SRAM_DQ_OE  <= is_wr;
        SRAM_WE_N   <= ~is_wr;
      end else if ((state_q == LO) && cnt_last) begin
        rd_lo_q     <= SRAM_DQ_IN;
        SRAM_ADDR   <= {word_q, 1'b1};
        SRAM_DQ_OUT <= wdata_q[31:16];
        SRAM_WE_N   <= ~wr_q;
      end else if ((state_q == HI) && cnt_last) begin
        SRAM_DQ_OE <= 1'b0;
        SRAM_WE_N  <= 1'b1;
        if (!wr_q) begin
          memory_out <= {SRAM_DQ_IN, rd_lo_q};
        end
      end else if (near_last) begin
        SRAM_WE_N <= 1'b1;
      end
    end
  end

endmodule
